systolic_4x4_sequencer: RTL and testbench

//  Job controller for the 4x4 fixed-point systolic array. It holds operand

---
 rtl/systolic_4x4_sequencer.sv | 161 ++++++++++++++++
 tb/tb_systolic_4x4_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_4x4_sequencer.sv
// Job controller for a 4x4 systolic array: holds operands A/B, clears the array,
// streams skewed west/north wavefronts, waits for drain and latches the result rows.
module systolic_4x4_sequencer #(
    parameter int unsigned BIT_WIDTH    = 16,
    parameter int unsigned FRAC_WIDTH   = 8,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic                   ld_sel,
    input  logic [3:0]             ld_addr,
    input  logic [BIT_WIDTH-1:0]   ld_data,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   arr_rst_n,
    output logic [BIT_WIDTH-1:0]   west_in0,
    output logic [BIT_WIDTH-1:0]   west_in1,
    output logic [BIT_WIDTH-1:0]   west_in2,
    output logic [BIT_WIDTH-1:0]   west_in3,
    output logic [BIT_WIDTH-1:0]   north_in0,
    output logic [BIT_WIDTH-1:0]   north_in1,
    output logic [BIT_WIDTH-1:0]   north_in2,
    output logic [BIT_WIDTH-1:0]   north_in3,
    input  logic [4*BIT_WIDTH-1:0] arr_row0,
    input  logic [4*BIT_WIDTH-1:0] arr_row1,
    input  logic [4*BIT_WIDTH-1:0] arr_row2,
    input  logic [4*BIT_WIDTH-1:0] arr_row3,
    output logic [4*BIT_WIDTH-1:0] res_row0,
    output logic [4*BIT_WIDTH-1:0] res_row1,
    output logic [4*BIT_WIDTH-1:0] res_row2,
    output logic [4*BIT_WIDTH-1:0] res_row3
);

    localparam int unsigned N           = 4;
    localparam int unsigned ROW_W       = N * BIT_WIDTH;
    localparam int unsigned FEED_CYCLES = 2 * N - 1;
    localparam int unsigned CNT_MAX     = (DRAIN_CYCLES > FEED_CYCLES) ? DRAIN_CYCLES : FEED_CYCLES;
    localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);

    // Q-format split and drain length must describe a meaningful array.
    if (FRAC_WIDTH >= BIT_WIDTH || DRAIN_CYCLES < 1) begin : g_param_check
        $error("systolic_4x4_sequencer: invalid FRAC_WIDTH or DRAIN_CYCLES");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_CAPTURE
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ld_ready_q, busy_q, done_q, arr_rst_n_q;
    logic [BIT_WIDTH-1:0] west_q  [N];
    logic [BIT_WIDTH-1:0] north_q [N];
    logic [BIT_WIDTH-1:0] west_d  [N];
    logic [BIT_WIDTH-1:0] north_d [N];
    logic [ROW_W-1:0]     res_q   [N];
    logic [ROW_W-1:0]     arr_rows[N];
    logic [BIT_WIDTH-1:0] a_mem   [N][N];
    logic [BIT_WIDTH-1:0] b_mem   [N][N];

    assign arr_rows[0] = arr_row0;
    assign arr_rows[1] = arr_row1;
    assign arr_rows[2] = arr_row2;
    assign arr_rows[3] = arr_row3;

    // Operand storage; writes only land while idle and are not reset.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && ld_valid) begin
            if (ld_sel) begin
                b_mem[ld_addr[3:2]][ld_addr[1:0]] <= ld_data;
            end else begin
                a_mem[ld_addr[3:2]][ld_addr[1:0]] <= ld_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        for (int i = 0; i < N; i++) begin
            west_d[i]  = '0;
            north_d[i] = '0;
        end
        case (state_q)
            S_IDLE:    if (start) state_d = S_CLEAR;
            S_CLEAR:   state_d = S_FEED;
            S_FEED: begin
                if (cnt_q == CNT_W'(FEED_CYCLES - 1)) state_d = S_DRAIN;
                else                                  cnt_d   = cnt_q + CNT_W'(1);
            end
            S_DRAIN: begin
                if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) state_d = S_CAPTURE;
                else                                   cnt_d   = cnt_q + CNT_W'(1);
            end
            S_CAPTURE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        // Edge values for the upcoming feed step: lane i is skewed by i cycles.
        if (state_d == S_FEED) begin
            for (int i = 0; i < N; i++) begin
                if (cnt_d >= CNT_W'(i) && cnt_d <= CNT_W'(i + N - 1)) begin
                    west_d[i]  = a_mem[2'(i)][2'(cnt_d - CNT_W'(i))];
                    north_d[i] = b_mem[2'(cnt_d - CNT_W'(i))][2'(i)];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ld_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            arr_rst_n_q <= 1'b1;
            for (int i = 0; i < N; i++) begin
                west_q[i]  <= '0;
                north_q[i] <= '0;
                res_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ld_ready_q  <= (state_d == S_IDLE);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_q == S_CAPTURE);
            arr_rst_n_q <= (state_d != S_CLEAR);
            for (int i = 0; i < N; i++) begin
                west_q[i]  <= west_d[i];
                north_q[i] <= north_d[i];
                if (state_q == S_CAPTURE) res_q[i] <= arr_rows[i];
            end
        end
    end

    assign ld_ready  = ld_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign arr_rst_n = arr_rst_n_q;
    assign west_in0  = west_q[0];
    assign west_in1  = west_q[1];
    assign west_in2  = west_q[2];
    assign west_in3  = west_q[3];
    assign north_in0 = north_q[0];
    assign north_in1 = north_q[1];
    assign north_in2 = north_q[2];
    assign north_in3 = north_q[3];
    assign res_row0  = res_q[0];
    assign res_row1  = res_q[1];
    assign res_row2  = res_q[2];
    assign res_row3  = res_q[3];

endmodule

// File: tb/tb_systolic_4x4_sequencer.sv
// Directed bench for systolic_4x4_sequencer; a behavioural output-stationary
// 4x4 array sits behind each instance (DRAIN_CYCLES 4 and 6).
module tb_systolic_4x4_sequencer;

    localparam logic [63:0] EXP1 = 64'h2800_1E00_1400_0A00;

    logic        clk = 1'b0;
    logic        rst_n, ld_valid, ld_sel, start, start6;
    logic [3:0]  ld_addr;
    logic [15:0] ld_data;
    logic [1:0]  ld_ready, busy, done, arr_rst_n;
    logic [15:0] west  [2][4];
    logic [15:0] north [2][4];
    logic [63:0] arr_row [2][4];
    logic [63:0] res_row [2][4];

    logic [15:0] pa  [2][4][4];
    logic [15:0] pb  [2][4][4];
    logic [15:0] acc [2][4][4];

    logic [15:0] s_w0 [41];
    logic [15:0] s_w3 [41];
    logic [15:0] s_n1 [41];
    logic [63:0] s_r0 [41];
    logic        s_busy [41];
    logic        s_ready[41];

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    for (genvar u = 0; u < 2; u++) begin : g_dut
        systolic_4x4_sequencer #(
            .BIT_WIDTH(16), .FRAC_WIDTH(8), .DRAIN_CYCLES(u == 0 ? 4 : 6)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .ld_valid(ld_valid), .ld_ready(ld_ready[u]), .ld_sel(ld_sel),
            .ld_addr(ld_addr), .ld_data(ld_data),
            .start(u == 0 ? start : start6), .busy(busy[u]), .done(done[u]),
            .arr_rst_n(arr_rst_n[u]),
            .west_in0(west[u][0]), .west_in1(west[u][1]),
            .west_in2(west[u][2]), .west_in3(west[u][3]),
            .north_in0(north[u][0]), .north_in1(north[u][1]),
            .north_in2(north[u][2]), .north_in3(north[u][3]),
            .arr_row0(arr_row[u][0]), .arr_row1(arr_row[u][1]),
            .arr_row2(arr_row[u][2]), .arr_row3(arr_row[u][3]),
            .res_row0(res_row[u][0]), .res_row1(res_row[u][1]),
            .res_row2(res_row[u][2]), .res_row3(res_row[u][3])
        );
    end

    function automatic logic [15:0] qmul(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] p;
        p = $signed(a) * $signed(b);
        return p[23:8];
    endfunction

    function automatic logic [15:0] a_in(input int u, input int i, input int j);
        if (j == 0) return west[u][i];
        return pa[u][i][j-1];
    endfunction

    function automatic logic [15:0] b_in(input int u, input int i, input int j);
        if (i == 0) return north[u][j];
        return pb[u][i-1][j];
    endfunction

    // Array model: operands hop one PE per cycle, each PE accumulates a*b.
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    if (!arr_rst_n[u]) begin
                        pa[u][i][j]  <= '0;
                        pb[u][i][j]  <= '0;
                        acc[u][i][j] <= '0;
                    end else begin
                        pa[u][i][j]  <= a_in(u, i, j);
                        pb[u][i][j]  <= b_in(u, i, j);
                        acc[u][i][j] <= acc[u][i][j] + qmul(a_in(u, i, j), b_in(u, i, j));
                    end
                end
    end

    always_comb begin
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < 4; i++)
                arr_row[u][i] = {acc[u][i][3], acc[u][i][2], acc[u][i][1], acc[u][i][0]};
    end

    task automatic load(input logic sel, input logic [3:0] addr, input logic [15:0] data);
        @(negedge clk);
        ld_valid = 1'b1; ld_sel = sel; ld_addr = addr; ld_data = data;
        @(posedge clk); #1;
        ld_valid = 1'b0;
    endtask

    // A rows [1,2,3,4] and B[k][j] = j+1 in Q8.8: both are 0x100*(col+1).
    task automatic load_scn1();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                load(1'b0, 4'(r * 4 + c), 16'(16'h0100 * (c + 1)));
                load(1'b1, 4'(r * 4 + c), 16'(16'h0100 * (c + 1)));
            end
    endtask

    // Issue start, then sample #1 after each edge; n=0 is the edge that samples start.
    task automatic run_job(input bit use6, input int inj_at, output int done_n, output int clr_n);
        int u;
        u = use6 ? 1 : 0;
        done_n = -1;
        clr_n  = 0;
        if (use6) start6 = 1'b1; else start = 1'b1;
        for (int n = 0; n <= 40; n++) begin
            @(posedge clk); #1;
            start = 1'b0; start6 = 1'b0; ld_valid = 1'b0;
            s_w0[n] = west[u][0]; s_w3[n] = west[u][3]; s_n1[n] = north[u][1];
            s_r0[n] = res_row[u][0]; s_busy[n] = busy[u]; s_ready[n] = ld_ready[u];
            if (!arr_rst_n[u]) clr_n++;
            if (done[u]) begin
                done_n = n;
                break;
            end
            if (n == inj_at) begin
                start = 1'b1; ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 4'h0; ld_data = 16'h7FFF;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; ld_valid = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
        start = 1'b0; start6 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vecs++;
        if ({ld_ready[0], busy[0], done[0], arr_rst_n[0]} !== 4'b1001) begin
            errs++;
            $display("FAIL reset_ctrl got %b exp 1001", {ld_ready[0], busy[0], done[0], arr_rst_n[0]});
        end
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (west[0][i] !== 16'h0 || north[0][i] !== 16'h0 || res_row[0][i] !== 64'h0) begin
                errs++;
                $display("FAIL reset_data[%0d] got w=%h n=%h r=%h exp 0", i, west[0][i], north[0][i], res_row[0][i]);
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_ones();
        int dn, cl;
        logic [15:0] exp;
        load_scn1();
        run_job(1'b0, -1, dn, cl);
        vecs++;
        if (dn !== 13) begin errs++; $display("FAIL ones_done_edge got %0d exp 13", dn); end
        vecs++;
        if (cl !== 1) begin errs++; $display("FAIL ones_clear_count got %0d exp 1", cl); end
        vecs++;
        if (s_busy[0] !== 1'b1 || s_ready[0] !== 1'b0) begin
            errs++; $display("FAIL ones_busy_clear got busy=%b ready=%b exp 1 0", s_busy[0], s_ready[0]);
        end
        for (int n = 1; n <= 5; n++) begin
            exp = (n <= 4) ? 16'(16'h0100 * n) : 16'h0;
            vecs++;
            if (s_w0[n] !== exp) begin errs++; $display("FAIL ones_west0 t=%0d got %h exp %h", n - 1, s_w0[n], exp); end
        end
        for (int n = 1; n <= 8; n++) begin
            exp = (n >= 4 && n <= 7) ? 16'(16'h0100 * (n - 3)) : 16'h0;
            vecs++;
            if (s_w3[n] !== exp) begin errs++; $display("FAIL ones_west3 t=%0d got %h exp %h", n - 1, s_w3[n], exp); end
        end
        for (int n = 1; n <= 6; n++) begin
            exp = (n >= 2 && n <= 5) ? 16'h0200 : 16'h0;
            vecs++;
            if (s_n1[n] !== exp) begin errs++; $display("FAIL ones_north1 t=%0d got %h exp %h", n - 1, s_n1[n], exp); end
        end
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (res_row[0][i] !== EXP1) begin errs++; $display("FAIL ones_res[%0d] got %h exp %h", i, res_row[0][i], EXP1); end
        end
        @(posedge clk); #1;
        vecs++;
        if (done[0] !== 1'b0) begin errs++; $display("FAIL ones_done_pulse got %b exp 0", done[0]); end
    endtask

    task automatic test_identity();
        int dn, cl;
        logic [63:0] exp_row [4];
        exp_row[0] = 64'h0400_0300_0200_0100;
        exp_row[1] = 64'h0800_0700_0600_0500;
        exp_row[2] = 64'h0C00_0B00_0A00_0900;
        exp_row[3] = 64'h1000_0F00_0E00_0D00;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                load(1'b0, 4'(r * 4 + c), (r == c) ? 16'h0100 : 16'h0000);
                load(1'b1, 4'(r * 4 + c), 16'(16'h0100 * (4 * r + c + 1)));
            end
        run_job(1'b0, -1, dn, cl);
        vecs++;
        if (dn !== 13) begin errs++; $display("FAIL ident_done_edge got %0d exp 13", dn); end
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (res_row[0][i] !== exp_row[i]) begin
                errs++; $display("FAIL ident_res[%0d] got %h exp %h", i, res_row[0][i], exp_row[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int dn, cl;
        load_scn1();
        run_job(1'b0, -1, dn, cl);
        vecs++;
        if (dn !== 13 || cl !== 1) begin errs++; $display("FAIL b2b_job1 got done=%0d clr=%0d exp 13 1", dn, cl); end
        // Restart from inside the done cycle.
        run_job(1'b0, -1, dn, cl);
        vecs++;
        if (dn !== 13 || cl !== 1) begin errs++; $display("FAIL b2b_job1b got done=%0d clr=%0d exp 13 1", dn, cl); end
        vecs++;
        if (s_r0[5] !== EXP1) begin errs++; $display("FAIL b2b_res_hold got %h exp %h", s_r0[5], EXP1); end
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (res_row[0][i] !== EXP1) begin errs++; $display("FAIL b2b_res1b[%0d] got %h exp %h", i, res_row[0][i], EXP1); end
        end
        for (int a = 0; a < 16; a++) load(1'b0, 4'(a), 16'h0000);
        run_job(1'b0, -1, dn, cl);
        vecs++;
        if (dn !== 13 || cl !== 1) begin errs++; $display("FAIL b2b_job2 got done=%0d clr=%0d exp 13 1", dn, cl); end
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (res_row[0][i] !== 64'h0) begin errs++; $display("FAIL b2b_res2[%0d] got %h exp 0", i, res_row[0][i]); end
        end
    endtask

    task automatic test_busy_ignore();
        int dn, cl;
        load_scn1();
        run_job(1'b0, 3, dn, cl);
        vecs++;
        if (dn !== 13) begin errs++; $display("FAIL busy_done_edge got %0d exp 13", dn); end
        vecs++;
        if (s_busy[3] !== 1'b1 || s_ready[3] !== 1'b0) begin
            errs++; $display("FAIL busy_feed_flags got busy=%b ready=%b exp 1 0", s_busy[3], s_ready[3]);
        end
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (res_row[0][i] !== EXP1) begin errs++; $display("FAIL busy_res[%0d] got %h exp %h", i, res_row[0][i], EXP1); end
        end
        @(posedge clk); #1;
        vecs++;
        if (busy[0] !== 1'b0) begin errs++; $display("FAIL busy_no_queue got %b exp 0", busy[0]); end
        run_job(1'b0, -1, dn, cl);
        vecs++;
        if (res_row[0][0] !== EXP1) begin errs++; $display("FAIL busy_a00_kept got %h exp %h", res_row[0][0], EXP1); end
    endtask

    task automatic test_mid_job_reset();
        int dn, cl;
        bit saw;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        vecs++;
        if (west[0][0] !== 16'h0400) begin errs++; $display("FAIL rst_pre_west0 got %h exp 0400", west[0][0]); end
        rst_n = 1'b0;
        #1;
        vecs++;
        if ({ld_ready[0], busy[0], done[0], arr_rst_n[0]} !== 4'b1001) begin
            errs++; $display("FAIL rst_mid_ctrl got %b exp 1001", {ld_ready[0], busy[0], done[0], arr_rst_n[0]});
        end
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (west[0][i] !== 16'h0 || north[0][i] !== 16'h0 || res_row[0][i] !== 64'h0) begin
                errs++;
                $display("FAIL rst_mid_data[%0d] got w=%h n=%h r=%h exp 0", i, west[0][i], north[0][i], res_row[0][i]);
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        saw = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done[0]) saw = 1'b1;
        end
        vecs++;
        if (saw !== 1'b0) begin errs++; $display("FAIL rst_no_done got %b exp 0", saw); end
        run_job(1'b0, -1, dn, cl);
        vecs++;
        if (dn !== 13) begin errs++; $display("FAIL rst_after_done got %0d exp 13", dn); end
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (res_row[0][i] !== EXP1) begin errs++; $display("FAIL rst_after_res[%0d] got %h exp %h", i, res_row[0][i], EXP1); end
        end
    endtask

    task automatic test_drain6();
        int dn, cl;
        load_scn1();
        run_job(1'b1, -1, dn, cl);
        vecs++;
        if (dn !== 15) begin errs++; $display("FAIL drain6_done_edge got %0d exp 15", dn); end
        vecs++;
        if (busy[0] !== 1'b0) begin errs++; $display("FAIL drain6_other_idle got %b exp 0", busy[0]); end
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (res_row[1][i] !== EXP1) begin errs++; $display("FAIL drain6_res[%0d] got %h exp %h", i, res_row[1][i], EXP1); end
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_identity();
        test_back_to_back();
        test_busy_ignore();
        test_mid_job_reset();
        test_drain6();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
